// File: rtl/ita_package.sv
// Shared constants and lane state encoding for the softmax serial divider array.
// Optional feature macro used by the lanes: ITA_SERDIV_FASTPATH_EN.
package ita_package;

  localparam int unsigned NumDiv              = 4;
  localparam int unsigned SoftmaxAccDataWidth = 17;
  localparam int unsigned DividerWidth        = 24;
  localparam logic [DividerWidth-1:0] Numerator = 24'h800000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } serdiv_state_e;

endpackage

// File: rtl/ita_serdiv_lane.sv
// One bit-serial restoring divider lane computing Numerator / divisor.
// ITA_SERDIV_FASTPATH_EN: divisors 0 and 1 bypass the iterations and finish in one cycle.
module ita_serdiv_lane #(
  parameter int unsigned InWidth      = ita_package::SoftmaxAccDataWidth,
  parameter int unsigned DividerWidth = ita_package::DividerWidth,
  parameter logic [DividerWidth-1:0] Numerator = ita_package::Numerator
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [InWidth-1:0]      div_inp_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [DividerWidth-1:0] oup_o,
  output logic                    busy_o
);
  import ita_package::*;

  localparam int unsigned CntWidth = $clog2(DividerWidth);

  serdiv_state_e           state_q, state_d;
  logic [InWidth-1:0]      divisor_q, divisor_d;
  logic [InWidth:0]        rem_q, rem_d;
  logic [DividerWidth-1:0] q_q, q_d;
  logic [DividerWidth-1:0] oup_q, oup_d;
  logic [CntWidth-1:0]     cnt_q, cnt_d;

  logic [InWidth+1:0]      rem_shift;
  logic                    sub_ok;

  always_comb begin
    rem_shift = {rem_q, q_q[DividerWidth-1]};
    sub_ok    = rem_shift >= (InWidth+2)'(divisor_q);

    state_d   = state_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    q_d       = q_q;
    oup_d     = oup_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          divisor_d = div_inp_i;
          rem_d     = '0;
          q_d       = Numerator;
          cnt_d     = CntWidth'(DividerWidth - 1);
          state_d   = BUSY;
`ifdef ITA_SERDIV_FASTPATH_EN
          if (div_inp_i <= InWidth'(1)) begin
            state_d = DONE;
            oup_d   = (div_inp_i == '0) ? '1 : Numerator;
          end
`endif
        end
      end
      BUSY: begin
        rem_d = sub_ok ? (InWidth+1)'(rem_shift - (InWidth+2)'(divisor_q))
                       : rem_shift[InWidth:0];
        q_d   = {q_q[DividerWidth-2:0], sub_ok};
        if (cnt_q == '0) begin
          state_d = DONE;
          // Zero divisor saturates explicitly rather than trusting the iteration.
          oup_d   = (divisor_q == '0) ? '1 : q_d;
        end else begin
          cnt_d = cnt_q - CntWidth'(1);
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
          oup_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        oup_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      divisor_q <= '0;
      rem_q     <= '0;
      q_q       <= '0;
      oup_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      q_q       <= q_d;
      oup_q     <= oup_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign busy_o  = (state_q != IDLE);
  assign oup_o   = oup_q;

endmodule

// File: rtl/ita_serdiv_array.sv
// Array of independent serial divider lanes answering the softmax division FIFO.
// Lane behaviour depends on ITA_SERDIV_FASTPATH_EN (see ita_serdiv_lane).
module ita_serdiv_array #(
  parameter int unsigned NumDiv       = ita_package::NumDiv,
  parameter int unsigned InWidth      = ita_package::SoftmaxAccDataWidth,
  parameter int unsigned DividerWidth = ita_package::DividerWidth,
  parameter logic [DividerWidth-1:0] Numerator = ita_package::Numerator
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [InWidth-1:0]                   div_inp_i,
  input  logic [NumDiv-1:0]                    div_valid_i,
  output logic [NumDiv-1:0]                    div_ready_o,
  output logic [NumDiv-1:0]                    div_valid_o,
  input  logic [NumDiv-1:0]                    div_ready_i,
  output logic [NumDiv-1:0][DividerWidth-1:0]  div_oup_o,
  output logic                                 busy_o
);
  import ita_package::*;

  logic [NumDiv-1:0] lane_busy;

  for (genvar gi = 0; gi < NumDiv; gi++) begin : g_lane
    ita_serdiv_lane #(
      .InWidth      (InWidth),
      .DividerWidth (DividerWidth),
      .Numerator    (Numerator)
    ) i_lane (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .div_inp_i (div_inp_i),
      .valid_i   (div_valid_i[gi]),
      .ready_o   (div_ready_o[gi]),
      .valid_o   (div_valid_o[gi]),
      .ready_i   (div_ready_i[gi]),
      .oup_o     (div_oup_o[gi]),
      .busy_o    (lane_busy[gi])
    );
  end

  assign busy_o = |lane_busy;

endmodule

// File: tb/tb_ita_serdiv_array.sv
// Directed and table-driven bench for ita_serdiv_array, golden floor(2**23/d) model.
module tb_ita_serdiv_array;

  logic              clk;
  logic              rst_n;
  logic [16:0]       div_inp_i;
  logic [3:0]        div_valid_i;
  logic [3:0]        div_ready_o;
  logic [3:0]        div_valid_o;
  logic [3:0]        div_ready_i;
  logic [3:0][23:0]  div_oup_o;
  logic              busy_o;

  int total = 0;
  int bad   = 0;

  ita_serdiv_array dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .div_inp_i   (div_inp_i),
    .div_valid_i (div_valid_i),
    .div_ready_o (div_ready_o),
    .div_valid_o (div_valid_o),
    .div_ready_i (div_ready_i),
    .div_oup_o   (div_oup_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          lane;
    logic [16:0] d;
    logic [23:0] q;
  } vec_t;

  vec_t        vecs[8];
  logic [23:0] exp_rr[4];
  logic        stream_on = 1'b0;
  int          got = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] golden(input logic [16:0] d);
    if (d == 17'd0) return 24'hFFFFFF;
    return 24'(32'd8388608 / 32'(d));
  endfunction

  function automatic int exp_lat(input logic [16:0] d);
`ifdef ITA_SERDIV_FASTPATH_EN
    if (d <= 17'd1) return 1;
`endif
    return 25;
  endfunction

  task automatic run_op(input int lane, input logic [16:0] d, input logic [23:0] expv);
    int n;
    div_inp_i         = d;
    div_valid_i[lane] = 1'b1;
    step();
    div_valid_i[lane] = 1'b0;
    n = 1;
    chk("accept_ready_drop", 32'(div_ready_o[lane]), 32'd0);
    while (!div_valid_o[lane] && n < 60) begin
      step();
      n++;
    end
    chk("latency", 32'(n), 32'(exp_lat(d)));
    chk("quotient", 32'(div_oup_o[lane]), 32'(expv));
    $display("lane %0d d=%0d q=0x%0h lat=%0d", lane, d, div_oup_o[lane], n);
    div_ready_i[lane] = 1'b1;
    step();
    div_ready_i[lane] = 1'b0;
    chk("post_hs_valid", 32'(div_valid_o[lane]), 32'd0);
    chk("post_hs_ready", 32'(div_ready_o[lane]), 32'd1);
    chk("post_hs_oup", 32'(div_oup_o[lane]), 32'd0);
  endtask

  always @(negedge clk) begin
    if (stream_on) begin
      for (int l = 0; l < 4; l++) begin
        if (div_valid_o[l]) begin
          chk("rr_quotient", 32'(div_oup_o[l]), 32'(exp_rr[l]));
          got++;
        end
      end
    end
  end

  initial begin
    int n;
    logic [16:0] d;

    vecs[0] = '{0, 17'd256,    24'd32768};
    vecs[1] = '{1, 17'd3,      24'd2796202};
    vecs[2] = '{2, 17'd131071, 24'd64};
    vecs[3] = '{3, 17'd0,      24'hFFFFFF};
    vecs[4] = '{0, 17'd1,      24'd8388608};
    vecs[5] = '{1, 17'd65536,  24'd128};
    vecs[6] = '{2, 17'd7,      24'd1198372};
    vecs[7] = '{3, 17'd100000, 24'd83};

    rst_n       = 1'b0;
    div_inp_i   = '0;
    div_valid_i = '0;
    div_ready_i = '0;
    #22;
    chk("rst_ready", 32'(div_ready_o), 32'hF);
    chk("rst_valid", 32'(div_valid_o), 32'h0);
    chk("rst_oup", 32'(div_oup_o[0] | div_oup_o[1] | div_oup_o[2] | div_oup_o[3]), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].lane, vecs[i].d, vecs[i].q);
    end

    // Back-pressure on lane 3 while lanes 0-2 accept.
    div_inp_i      = 17'd5;
    div_valid_i[3] = 1'b1;
    step();
    div_valid_i[3] = 1'b0;
    n = 1;
    while (!div_valid_o[3] && n < 60) begin
      step();
      n++;
    end
    chk("bp_latency", 32'(n), 32'd25);
    chk("bp_quotient", 32'(div_oup_o[3]), 32'd1677721);
    for (int k = 0; k < 10; k++) begin
      if (k == 2) begin
        div_inp_i   = 17'd9;
        div_valid_i = 4'hF;
      end
      step();
      if (k == 2) begin
        div_valid_i = 4'h0;
        chk("bp_others_accept", 32'(div_ready_o[2:0]), 32'd0);
      end
      chk("bp_hold_valid", 32'(div_valid_o[3]), 32'd1);
      chk("bp_hold_oup", 32'(div_oup_o[3]), 32'd1677721);
    end
    $display("lane 3 held q=0x%0h for 10 cycles", div_oup_o[3]);
    div_ready_i[3] = 1'b1;
    step();
    div_ready_i[3] = 1'b0;
    chk("bp_release_ready", 32'(div_ready_o[3]), 32'd1);
    chk("bp_ignored_valid", 32'(div_valid_o[3]), 32'd0);
    n = 0;
    while (div_valid_o[2:0] != 3'b111 && n < 60) begin
      step();
      n++;
    end
    for (int l = 0; l < 3; l++) begin
      chk("bp_other_quot", 32'(div_oup_o[l]), 32'd932067);
    end
    $display("lanes 0-2 d=9 q=0x%0h", div_oup_o[0]);
    div_ready_i = 4'h7;
    step();
    div_ready_i = 4'h0;
    chk("bp_idle", 32'(busy_o), 32'd0);

    // Round-robin stream of random divisors.
    div_ready_i = 4'hF;
    stream_on   = 1'b1;
    for (int i = 0; i < 64; i++) begin
      int l;
      l = i % 4;
      n = 0;
      while (!div_ready_o[l] && n < 200) begin
        step();
        n++;
      end
      if (n >= 200) chk("rr_ready_timeout", 32'(div_ready_o[l]), 32'd1);
      d = (i % 16 == 5) ? 17'(i % 3) : 17'($urandom_range(0, 131071));
      exp_rr[l]      = golden(d);
      div_inp_i      = d;
      div_valid_i[l] = 1'b1;
      step();
      div_valid_i[l] = 1'b0;
      $display("rr issue %0d lane %0d d=%0d exp=0x%0h", i, l, d, exp_rr[l]);
    end
    n = 0;
    while (got < 64 && n < 2000) begin
      step();
      n++;
    end
    chk("rr_count", 32'(got), 32'd64);
    step();
    stream_on   = 1'b0;
    div_ready_i = 4'h0;
    chk("rr_busy_low", 32'(busy_o), 32'd0);

    // Reset in the middle of an iteration.
    div_inp_i      = 17'd256;
    div_valid_i[0] = 1'b1;
    step();
    div_valid_i[0] = 1'b0;
    repeat (10) step();
    chk("mid_busy", 32'(busy_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(div_ready_o), 32'hF);
    chk("mid_rst_valid", 32'(div_valid_o), 32'h0);
    chk("mid_rst_oup", 32'(div_oup_o[0]), 32'h0);
    chk("mid_rst_busy", 32'(busy_o), 32'h0);
    $display("mid-busy reset applied");
    #10 rst_n = 1'b1;
    step();
    run_op(0, 17'd1000, 24'd8388);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
